// File: rtl/nibble_load_ctrl_pkg.sv
// Shared types and constants for the nibble-assembly load controller.
package nibble_ctrl_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        CAP,
        OUT
    } state_t;

endpackage

// File: rtl/nibble_load_ctrl_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not go last wins.
module rr_arb2
    import nibble_ctrl_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_src,
    output logic any_req,
    output logic gnt
);

    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            gnt = ~last_src;
        end else if (req1) begin
            gnt = SRC1;
        end else begin
            gnt = SRC0;
        end
    end

endmodule

// File: rtl/nibble_load_ctrl.sv
// Sequences the nibble shifter: grants one requester, loads low then high nibble,
// captures the assembled byte and offers it downstream on valid/ready.
//
// state | meaning
// IDLE  | no transfer; arbitrate and register grant
// LO    | waiting for low nibble from granted requester
// HI    | waiting for high nibble from granted requester
// CAP   | shifter holds both nibbles; capture byte
// OUT   | byte offered downstream until out_ready
module nibble_load_ctrl
    import nibble_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [NIBBLE_W-1:0] req0_nibble,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [NIBBLE_W-1:0] req1_nibble,
    output logic                req1_ready,
    output logic [NIBBLE_W-1:0] shf_data,
    output logic                shf_down,
    output logic                shf_up,
    input  logic [BYTE_W-1:0]   shf_byte,
    output logic                out_valid,
    output logic [BYTE_W-1:0]   out_byte,
    output logic                out_src,
    input  logic                out_ready,
    output logic                abort
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t              state_q, state_d;
    logic                g_q, g_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]   out_byte_q, out_byte_d;
    logic                out_src_q, out_src_d;
    logic                abort_q, abort_d;

    logic                arb_any, arb_gnt;
    logic                g_valid, waiting, accept, timed_out;
    logic [NIBBLE_W-1:0] g_nibble;

    rr_arb2 u_arb (
        .req0     (req0_valid),
        .req1     (req1_valid),
        .last_src (last_q),
        .any_req  (arb_any),
        .gnt      (arb_gnt)
    );

    // Handshake and strobes are gated by rst so nothing is accepted in a reset cycle.
    always_comb begin
        g_valid    = (g_q == SRC1) ? req1_valid : req0_valid;
        g_nibble   = (g_q == SRC1) ? req1_nibble : req0_nibble;
        waiting    = ((state_q == LO) || (state_q == HI)) && !rst;
        accept     = waiting && g_valid;
        req0_ready = waiting && (g_q == SRC0);
        req1_ready = waiting && (g_q == SRC1);
        shf_down   = accept && (state_q == LO);
        shf_up     = accept && (state_q == HI);
        shf_data   = accept ? g_nibble : '0;
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        out_src_d   = out_src_q;
        abort_d     = 1'b0;
        timed_out   = (TIMEOUT > 0) && (cnt_q == CNT_LAST);
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    g_d     = arb_gnt;
                    cnt_d   = '0;
                    state_d = LO;
                end
            end
            LO, HI: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = (state_q == LO) ? HI : CAP;
                end else if (timed_out) begin
                    // Stalled requester loses its turn; the other side is favoured next.
                    abort_d = 1'b1;
                    last_d  = g_q;
                    state_d = IDLE;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAP: begin
                out_byte_d  = shf_byte;
                out_src_d   = g_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    last_d      = g_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            g_q         <= SRC0;
            last_q      <= SRC1;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_src_q   <= SRC0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_src_q   <= out_src_d;
            abort_q     <= abort_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign out_src   = out_src_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_nibble_load_ctrl.sv
// Bench for nibble_load_ctrl: two instances (TIMEOUT 3 and 0) share one stimulus table
// and are each checked every cycle against a transfer-level model.
module tb_nibble_load_ctrl;
    import nibble_ctrl_pkg::*;

    localparam int TO_A = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       r0v = 1'b0, r1v = 1'b0, ordy = 1'b1;
    logic [3:0] n0 = 4'h0, n1 = 4'h0;

    logic       rdy0 [2];
    logic       rdy1 [2];
    logic       down [2];
    logic       up   [2];
    logic       ov   [2];
    logic       osrc [2];
    logic       abrt [2];
    logic [3:0] sdata [2];
    logic [7:0] obyte [2];
    logic [7:0] sbyte [2];
    logic [3:0] sh_lo [2] = '{4'h0, 4'h0};
    logic [3:0] sh_hi [2] = '{4'h0, 4'h0};

    nibble_load_ctrl #(.TIMEOUT(TO_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_nibble(n0), .req0_ready(rdy0[0]),
        .req1_valid(r1v), .req1_nibble(n1), .req1_ready(rdy1[0]),
        .shf_data(sdata[0]), .shf_down(down[0]), .shf_up(up[0]), .shf_byte(sbyte[0]),
        .out_valid(ov[0]), .out_byte(obyte[0]), .out_src(osrc[0]), .out_ready(ordy),
        .abort(abrt[0])
    );

    nibble_load_ctrl #(.TIMEOUT(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_nibble(n0), .req0_ready(rdy0[1]),
        .req1_valid(r1v), .req1_nibble(n1), .req1_ready(rdy1[1]),
        .shf_data(sdata[1]), .shf_down(down[1]), .shf_up(up[1]), .shf_byte(sbyte[1]),
        .out_valid(ov[1]), .out_byte(obyte[1]), .out_src(osrc[1]), .out_ready(ordy),
        .abort(abrt[1])
    );

    // Shifter stand-ins (no reset, like the real shifter).
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (down[i]) sh_lo[i] <= sdata[i];
            if (up[i])   sh_hi[i] <= sdata[i];
        end
    end
    assign sbyte[0] = {sh_hi[0], sh_lo[0]};
    assign sbyte[1] = {sh_hi[1], sh_lo[1]};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", name, d, $time, act, exp);
        end
    endtask

    function automatic int to_of(input int i);
        return (i == 0) ? TO_A : 0;
    endfunction

    // Transfer-level model: which requester owns the transfer, how many nibbles it has
    // delivered, how long it has stalled, and whether a byte is awaiting capture/offer.
    bit         m_on = 1'b0;
    bit         m_act [2];
    bit         m_g   [2];
    int         m_got [2];
    int         m_wait [2];
    logic [3:0] m_nib [2][2];
    bit         m_cap [2];
    bit         m_offer [2];
    logic [7:0] m_byte [2];
    bit         m_src [2];
    bit         m_abort [2];
    bit         m_last [2];

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] = 0; m_g[i] = 0; m_got[i] = 0; m_wait[i] = 0; m_cap[i] = 0;
                m_offer[i] = 0; m_byte[i] = 8'h00; m_src[i] = 0; m_abort[i] = 0; m_last[i] = 1;
            end else begin
                m_abort[i] = 0;
                if (m_offer[i]) begin
                    if (ordy) begin
                        m_offer[i] = 0;
                        m_last[i]  = m_src[i];
                    end
                end else if (m_cap[i]) begin
                    m_byte[i]  = {m_nib[i][1], m_nib[i][0]};
                    m_src[i]   = m_g[i];
                    m_offer[i] = 1;
                    m_cap[i]   = 0;
                end else if (m_act[i]) begin
                    if (m_g[i] ? r1v : r0v) begin
                        m_nib[i][m_got[i]] = m_g[i] ? n1 : n0;
                        m_got[i]++;
                        m_wait[i] = 0;
                        if (m_got[i] == 2) begin
                            m_act[i] = 0;
                            m_cap[i] = 1;
                        end
                    end else begin
                        m_wait[i]++;
                        if (to_of(i) > 0 && m_wait[i] == to_of(i)) begin
                            m_abort[i] = 1;
                            m_act[i]   = 0;
                            m_last[i]  = m_g[i];
                        end
                    end
                end else if (r0v || r1v) begin
                    m_g[i]    = (r0v && r1v) ? !m_last[i] : r1v;
                    m_act[i]  = 1;
                    m_got[i]  = 0;
                    m_wait[i] = 0;
                end
            end
        end
        if (rst) m_on = 1'b1;
    end

    task automatic cmp_inst(input int i);
        bit         w, acc;
        logic [3:0] nb;
        w   = m_act[i] && !rst;
        acc = w && (m_g[i] ? r1v : r0v);
        nb  = m_g[i] ? n1 : n0;
        chk("req0_ready", i, {7'd0, rdy0[i]}, {7'd0, w && !m_g[i]});
        chk("req1_ready", i, {7'd0, rdy1[i]}, {7'd0, w && m_g[i]});
        chk("shf_down",   i, {7'd0, down[i]}, {7'd0, acc && (m_got[i] == 0)});
        chk("shf_up",     i, {7'd0, up[i]},   {7'd0, acc && (m_got[i] == 1)});
        chk("shf_data",   i, {4'd0, sdata[i]}, acc ? {4'd0, nb} : 8'h00);
        chk("out_valid",  i, {7'd0, ov[i]},   {7'd0, m_offer[i]});
        chk("out_byte",   i, obyte[i], m_byte[i]);
        chk("out_src",    i, {7'd0, osrc[i]}, {7'd0, m_src[i]});
        chk("abort",      i, {7'd0, abrt[i]}, {7'd0, m_abort[i]});
    endtask

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            cmp_inst(0);
            cmp_inst(1);
        end
    end

    // Directed stimulus table; e() pins hand-computed values for one instance on a row.
    typedef struct {
        logic       rst, r0v, r1v, ordy;
        logic [3:0] n0, n1;
        bit         has_e;
        int         d;
        logic [3:0] e_sig;   // {req0_ready, req1_ready, shf_down, shf_up}
        logic [3:0] e_data;
        logic       e_ov;
        logic [7:0] e_byte;
        logic       e_src;
        logic       e_abort;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, input logic a0, input logic [3:0] b0,
                     input logic a1, input logic [3:0] b1, input logic o);
        vec_t t;
        t = '{rst: r, r0v: a0, r1v: a1, ordy: o, n0: b0, n1: b1, has_e: 0, d: 0,
              e_sig: 4'h0, e_data: 4'h0, e_ov: 0, e_byte: 8'h00, e_src: 0, e_abort: 0};
        vq.push_back(t);
    endtask

    task automatic e(input int d, input logic [3:0] sig, input logic [3:0] data,
                     input logic ovl, input logic [7:0] byt, input logic src, input logic ab);
        vec_t t;
        t = vq.pop_back();
        t.has_e = 1; t.d = d; t.e_sig = sig; t.e_data = data;
        t.e_ov = ovl; t.e_byte = byt; t.e_src = src; t.e_abort = ab;
        vq.push_back(t);
    endtask

    task automatic rr();
        v(1, 0, 0, 0, 0, 1);
        v(1, 0, 0, 0, 0, 1);
    endtask

    task automatic z(input int n);
        for (int k = 0; k < n; k++) v(0, 0, 0, 0, 0, 1);
    endtask

    task automatic lit(input vec_t t);
        chk("lit_req0_ready", t.d, {7'd0, rdy0[t.d]}, {7'd0, t.e_sig[3]});
        chk("lit_req1_ready", t.d, {7'd0, rdy1[t.d]}, {7'd0, t.e_sig[2]});
        chk("lit_shf_down",   t.d, {7'd0, down[t.d]}, {7'd0, t.e_sig[1]});
        chk("lit_shf_up",     t.d, {7'd0, up[t.d]},   {7'd0, t.e_sig[0]});
        chk("lit_shf_data",   t.d, {4'd0, sdata[t.d]}, {4'd0, t.e_data});
        chk("lit_out_valid",  t.d, {7'd0, ov[t.d]},   {7'd0, t.e_ov});
        chk("lit_out_byte",   t.d, obyte[t.d], t.e_byte);
        chk("lit_out_src",    t.d, {7'd0, osrc[t.d]}, {7'd0, t.e_src});
        chk("lit_abort",      t.d, {7'd0, abrt[t.d]}, {7'd0, t.e_abort});
    endtask

    initial begin
        // reset values
        rr(); v(0, 0, 0, 0, 0, 1); e(0, 4'b0000, 4'h0, 0, 8'h00, 0, 0);
        // single byte from req0
        v(0, 1, 4'h5, 0, 0, 1); e(0, 4'b0000, 4'h0, 0, 8'h00, 0, 0);
        v(0, 1, 4'h5, 0, 0, 1); e(0, 4'b1010, 4'h5, 0, 8'h00, 0, 0);
        v(0, 1, 4'hA, 0, 0, 1); e(0, 4'b1001, 4'hA, 0, 8'h00, 0, 0);
        v(0, 0, 0, 0, 0, 1);    e(0, 4'b0000, 4'h0, 0, 8'h00, 0, 0);
        v(0, 0, 0, 0, 0, 1);    e(0, 4'b0000, 4'h0, 1, 8'hA5, 0, 0);
        v(0, 0, 0, 0, 0, 1);    e(0, 4'b0000, 4'h0, 0, 8'hA5, 0, 0);
        // backpressure, requester keeps asking while the byte is held
        v(0, 1, 4'h5, 0, 0, 0); v(0, 1, 4'h5, 0, 0, 0); v(0, 1, 4'hA, 0, 0, 0);
        v(0, 1, 4'h3, 0, 0, 0); e(0, 4'b0000, 4'h0, 0, 8'hA5, 0, 0);
        for (int k = 0; k < 6; k++) begin
            v(0, 1, 4'h3, 0, 0, 0); e(0, 4'b0000, 4'h0, 1, 8'hA5, 0, 0);
        end
        v(0, 1, 4'h3, 0, 0, 1); e(0, 4'b0000, 4'h0, 1, 8'hA5, 0, 0);
        v(0, 0, 0, 0, 0, 1);    e(0, 4'b0000, 4'h0, 0, 8'hA5, 0, 0);
        // both requesters from reset
        rr();
        v(0, 1, 4'h1, 1, 4'h3, 1); e(0, 4'b0000, 4'h0, 0, 8'h00, 0, 0);
        v(0, 1, 4'h1, 1, 4'h3, 1); e(0, 4'b1010, 4'h1, 0, 8'h00, 0, 0);
        v(0, 1, 4'h2, 1, 4'h3, 1); e(0, 4'b1001, 4'h2, 0, 8'h00, 0, 0);
        v(0, 0, 0, 1, 4'h3, 1);    e(0, 4'b0000, 4'h0, 0, 8'h00, 0, 0);
        v(0, 0, 0, 1, 4'h3, 1);    e(0, 4'b0000, 4'h0, 1, 8'h21, 0, 0);
        v(0, 0, 0, 1, 4'h3, 1);    e(0, 4'b0000, 4'h0, 0, 8'h21, 0, 0);
        v(0, 0, 0, 1, 4'h3, 1);    e(0, 4'b0110, 4'h3, 0, 8'h21, 0, 0);
        v(0, 0, 0, 1, 4'h4, 1);    e(0, 4'b0101, 4'h4, 0, 8'h21, 0, 0);
        v(0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0, 0, 1);       e(0, 4'b0000, 4'h0, 1, 8'h43, 1, 0);
        v(0, 0, 0, 0, 0, 1);
        // req1 stalls after its low nibble
        v(0, 0, 0, 1, 4'h7, 1);    e(0, 4'b0000, 4'h0, 0, 8'h43, 1, 0);
        v(0, 0, 0, 1, 4'h7, 1);    e(0, 4'b0110, 4'h7, 0, 8'h43, 1, 0);
        v(0, 0, 0, 0, 0, 1);       e(0, 4'b0100, 4'h0, 0, 8'h43, 1, 0);
        v(0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0, 0, 1);       e(0, 4'b0100, 4'h0, 0, 8'h43, 1, 0);
        v(0, 1, 4'h9, 1, 4'h8, 1); e(0, 4'b0000, 4'h0, 0, 8'h43, 1, 1);
        v(0, 1, 4'h9, 1, 4'h8, 1); e(0, 4'b1010, 4'h9, 0, 8'h43, 1, 0);
        v(0, 1, 4'h6, 0, 0, 1);    e(1, 4'b0000, 4'h0, 1, 8'h87, 1, 0);
        v(0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0, 0, 1);       e(0, 4'b0000, 4'h0, 1, 8'h69, 0, 0);
        v(0, 0, 0, 0, 0, 1);
        // reset while in HI
        v(0, 1, 4'h2, 0, 0, 1); v(0, 1, 4'h2, 0, 0, 1); v(1, 1, 4'h3, 0, 0, 1);
        v(0, 1, 4'h3, 0, 0, 1); e(0, 4'b0000, 4'h0, 0, 8'h00, 0, 0);
        v(0, 1, 4'h3, 0, 0, 1); e(0, 4'b1010, 4'h3, 0, 8'h00, 0, 0);
        v(0, 1, 4'h4, 0, 0, 1);
        v(0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0, 0, 1);    e(0, 4'b0000, 4'h0, 1, 8'h43, 0, 0);
        v(0, 0, 0, 0, 0, 1);
        // long stall in LO: only the TIMEOUT=0 instance keeps waiting
        v(0, 0, 0, 1, 4'h5, 1);
        for (int k = 1; k <= 100; k++) begin
            v(0, 0, 0, 0, 0, 1);
            if (k == 4)   e(0, 4'b0000, 4'h0, 0, 8'h43, 0, 1);
            if (k == 100) e(1, 4'b0100, 4'h0, 0, 8'h43, 0, 0);
        end
        v(0, 0, 0, 1, 4'h5, 1); e(1, 4'b0110, 4'h5, 0, 8'h43, 0, 0);
        v(0, 0, 0, 1, 4'h6, 1); e(1, 4'b0101, 4'h6, 0, 8'h43, 0, 0);
        v(0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0, 0, 1);    e(1, 4'b0000, 4'h0, 1, 8'h65, 1, 0);
        z(6);

        foreach (vq[k]) begin
            @(posedge clk);
            #1;
            rst  = vq[k].rst;
            r0v  = vq[k].r0v;
            n0   = vq[k].n0;
            r1v  = vq[k].r1v;
            n1   = vq[k].n1;
            ordy = vq[k].ordy;
            @(negedge clk);
            #1;
            if (vq[k].has_e) lit(vq[k]);
        end
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
